// File: rtl/shift_add_multiplier_pkg.sv
// Shared state encoding and counter sizing for the shift-add multiplier.
// Imported by the multiplier top; no logic of its own.
package mul_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic int CNT_W(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Request/result bundle between the upstream issuer and the multiplier.
// master = issuer side, slave = multiplier side.
interface shift_add_multiplier_if #(
  parameter int bw = 4
);
  logic            start;
  logic [bw:1]     A;
  logic [bw:1]     B;
  logic            busy;
  logic            done;
  logic [2*bw:1]   product;

  modport master (
    output start, A, B,
    input  busy, done, product
  );

  modport slave (
    input  start, A, B,
    output busy, done, product
  );
endinterface

// File: rtl/shift_add_multiplier_rca.sv
// Plain ripple-carry adder feeding the multiplier accumulation stage.
// Carry chain is explicit so each bit is one full adder.
module ripple_carry_adder #(
  parameter int bw = 4
) (
  input  logic [bw:1] a_i,
  input  logic [bw:1] b_i,
  input  logic        cin_i,
  output logic [bw:1] sum_o,
  output logic        cout_o
);

  logic [bw+1:1] c;

  assign c[1] = cin_i;

  for (genvar i = 1; i <= bw; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) |
                      (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[bw+1];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned bw x bw shift-add multiplier, one iteration per clock.
// Optional MUL_EARLY_TERM_EN ends BUSY once the remaining multiplier bits are zero.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int bw = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shift_add_multiplier_if.slave bus
);

  localparam int CW = CNT_W(bw);
  localparam logic [CW-1:0] LAST = CW'(bw - 1);

  logic [1:0]    state_q, state_d;
  logic [bw:1]   m_q, m_d;
  logic [bw:1]   q_q, q_d;
  logic [bw:1]   acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*bw:1] prod_q, prod_d;

  logic [bw:1]   addend;
  logic [bw:1]   sum;
  logic          cout;
  logic [bw:1]   acc_n;
  logic [bw:1]   q_n;
  logic          fin;
  logic [2*bw:1] res;

  assign addend = q_q[1] ? m_q : '0;

  ripple_carry_adder #(.bw(bw)) u_add (
    .a_i    (acc_q),
    .b_i    (addend),
    .cin_i  (1'b0),
    .sum_o  (sum),
    .cout_o (cout)
  );

  // {c,s,Q} >> 1 with the vacated top bit dropped
  assign {acc_n, q_n} = {cout, sum, q_q[bw:2]};

`ifdef MUL_EARLY_TERM_EN
  logic [CW-1:0] rem;
  logic [bw:1]   mask;

  assign rem  = LAST - cnt_q;
  assign mask = (bw'(1) << rem) - bw'(1);
  assign fin  = ((q_n & mask) == '0);
  assign res  = {acc_n, q_n} >> rem;
`else
  assign fin  = (cnt_q == LAST);
  assign res  = {acc_n, q_n};
`endif

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      S_BUSY: begin
        acc_d = acc_n;
        q_d   = q_n;
        cnt_d = cnt_q + CW'(1);
        if (fin) begin
          prod_d  = res;
          state_d = S_DONE;
        end
      end
      default: begin
        if (bus.start) begin
          state_d = S_BUSY;
          m_d     = bus.A;
          q_d     = bus.B;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.busy    = (state_q == S_BUSY);
  assign bus.done    = (state_q == S_DONE);
  assign bus.product = prod_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier at bw=4 plus a bw=8 sweep.
// Cycle k is the interval after the k-th rising edge; I/O at falling edges.
module tb_shift_add_multiplier;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

`ifdef MUL_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  shift_add_multiplier_if #(.bw(4)) bus4 ();
  shift_add_multiplier_if #(.bw(8)) bus8 ();

  shift_add_multiplier #(.bw(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  shift_add_multiplier #(.bw(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    bus4.start = 1'b0; bus4.A = '0; bus4.B = '0;
    bus8.start = 1'b0; bus8.A = '0; bus8.B = '0;
    #1;
    n_chk++;
    if (bus4.busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_busy got %b exp 0", bus4.busy);
    end
    n_chk++;
    if (bus4.done !== 1'b0) begin
      n_fail++; $display("FAIL rst_done got %b exp 0", bus4.done);
    end
    n_chk++;
    if (bus4.product !== 8'h00) begin
      n_fail++; $display("FAIL rst_prod got %h exp 00", bus4.product);
    end
    n_chk++;
    if (bus8.product !== 16'h0000 || bus8.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_8 got p=%h b=%b exp 0000/0",
               bus8.product, bus8.busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full();
    @(negedge clk);
    bus4.start = 1'b1; bus4.A = 4'hF; bus4.B = 4'hF;
    @(negedge clk);
    bus4.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (!ET || c == 1) begin
        n_chk++;
        if (bus4.busy !== 1'b1 || bus4.done !== 1'b0) begin
          n_fail++;
          $display("FAIL full_busy c%0d got b=%b d=%b exp 1/0",
                   c, bus4.busy, bus4.done);
        end
      end
      @(negedge clk);
    end
    n_chk++;
    if (bus4.done !== 1'b1 || bus4.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_done c5 got d=%b b=%b exp 1/0",
               bus4.done, bus4.busy);
    end
    n_chk++;
    if (bus4.product !== 8'hE1) begin
      n_fail++; $display("FAIL full_prod got %h exp e1", bus4.product);
    end
    @(negedge clk);
    n_chk++;
    if (bus4.done !== 1'b0 || bus4.product !== 8'hE1) begin
      n_fail++;
      $display("FAIL full_hold got d=%b p=%h exp 0/e1",
               bus4.done, bus4.product);
    end
  endtask

  task automatic test_zero();
    int nb;
    int exp_nb;
    exp_nb = ET ? 1 : 4;
    nb = 0;
    @(negedge clk);
    bus4.start = 1'b1; bus4.A = 4'h7; bus4.B = 4'h0;
    @(negedge clk);
    bus4.start = 1'b0;
    for (int t = 0; t < 20 && bus4.done !== 1'b1; t++) begin
      if (bus4.busy === 1'b1) nb++;
      @(negedge clk);
    end
    n_chk++;
    if (bus4.done !== 1'b1) begin
      n_fail++; $display("FAIL zero_timeout got done=%b exp 1", bus4.done);
    end
    n_chk++;
    if (nb != exp_nb) begin
      n_fail++; $display("FAIL zero_lat got %0d exp %0d", nb, exp_nb);
    end
    n_chk++;
    if (bus4.product !== 8'h00) begin
      n_fail++; $display("FAIL zero_prod got %h exp 00", bus4.product);
    end
    @(negedge clk);
  endtask

  task automatic test_ignored();
    @(negedge clk);
    bus4.start = 1'b1; bus4.A = 4'h3; bus4.B = 4'h5;
    @(negedge clk);
    bus4.start = 1'b0;
    @(negedge clk);
    bus4.start = 1'b1; bus4.A = 4'hF; bus4.B = 4'hF;
    @(negedge clk);
    bus4.start = 1'b0;
    for (int t = 0; t < 20 && bus4.done !== 1'b1; t++)
      @(negedge clk);
    n_chk++;
    if (bus4.done !== 1'b1 || bus4.product !== 8'h0F) begin
      n_fail++;
      $display("FAIL ign_prod got d=%b p=%h exp 1/0f",
               bus4.done, bus4.product);
    end
    @(negedge clk);
    n_chk++;
    if (bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_idle got b=%b d=%b exp 0/0",
               bus4.busy, bus4.done);
    end
  endtask

  task automatic test_abort();
    int seen;
    seen = 0;
    @(negedge clk);
    bus4.start = 1'b1; bus4.A = 4'h9; bus4.B = 4'h6;
    @(negedge clk);
    bus4.start = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (bus4.busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_run got b=%b exp 1", bus4.busy);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 ||
        bus4.product !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_clr got b=%b d=%b p=%h exp 0/0/00",
               bus4.busy, bus4.done, bus4.product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 10; t++) begin
      if (bus4.done === 1'b1 || bus4.busy === 1'b1) seen++;
      @(negedge clk);
    end
    n_chk++;
    if (seen != 0 || bus4.product !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_quiet got act=%0d p=%h exp 0/00",
               seen, bus4.product);
    end
  endtask

  task automatic test_back_to_back();
    int nd;
    int dc [2];
    logic [7:0] dp [2];
    int e1;
    int e2;
    e1 = ET ? 3 : 5;
    e2 = ET ? 7 : 10;
    nd = 0;
    dc[0] = -1; dc[1] = -1;
    dp[0] = '0; dp[1] = '0;
    @(negedge clk);
    bus4.start = 1'b1; bus4.A = 4'h2; bus4.B = 4'h3;
    @(negedge clk);
    bus4.A = 4'h4; bus4.B = 4'h5;
    for (int c = 1; c <= 14; c++) begin
      if (bus4.done === 1'b1 && nd < 2) begin
        dc[nd] = c;
        dp[nd] = bus4.product;
        nd++;
        if (nd == 2) bus4.start = 1'b0;
      end
      @(negedge clk);
    end
    bus4.start = 1'b0;
    n_chk++;
    if (nd != 2) begin
      n_fail++; $display("FAIL b2b_count got %0d exp 2", nd);
    end
    n_chk++;
    if (dc[0] != e1 || dc[1] != e2) begin
      n_fail++;
      $display("FAIL b2b_cycles got %0d,%0d exp %0d,%0d",
               dc[0], dc[1], e1, e2);
    end
    n_chk++;
    if (dp[0] !== 8'h06 || dp[1] !== 8'h14) begin
      n_fail++;
      $display("FAIL b2b_prod got %h,%h exp 06,14", dp[0], dp[1]);
    end
  endtask

  task automatic test_sweep8();
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_p;
    int          nb;
    for (int i = 0; i < 256; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if (i == 0) begin a = 8'hFF; b = 8'hFF; end
      if (i == 1) begin a = 8'h00; b = 8'hA5; end
      if (i == 2) begin a = 8'h5A; b = 8'h00; end
      if (i == 3) begin a = 8'h01; b = 8'h80; end
      exp_p = 16'(a) * 16'(b);
      nb = 0;
      bus8.start = 1'b1; bus8.A = a; bus8.B = b;
      @(negedge clk);
      bus8.start = 1'b0;
      for (int t = 0; t < 20 && bus8.done !== 1'b1; t++) begin
        if (bus8.busy === 1'b1) nb++;
        @(negedge clk);
      end
      n_chk++;
      if (bus8.done !== 1'b1 || bus8.product !== exp_p) begin
        n_fail++;
        $display("FAIL sweep %0d %h*%h got d=%b p=%h exp 1/%h",
                 i, a, b, bus8.done, bus8.product, exp_p);
      end
      if (!ET) begin
        n_chk++;
        if (nb != 8) begin
          n_fail++;
          $display("FAIL sweep_lat %0d got %0d exp 8", i, nb);
        end
      end
      @(negedge clk);
      n_chk++;
      if (bus8.done !== 1'b0) begin
        n_fail++;
        $display("FAIL sweep_pulse %0d got d=%b exp 0", i, bus8.done);
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_full();
    test_zero();
    test_ignored();
    test_abort();
    test_back_to_back();
    test_sweep8();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
